// File: rtl/pc_sequencer.sv
// Program-flow controller: owns the program counter and sequences fetch
// through ordinary step, branch, single-cycle load stall and halt.
module pc_sequencer #(
  parameter int PC_W     = 10,
  parameter int START_PC = 0,
  parameter int LUT_W    = 5,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [8:0]       Instruction,
  input  logic             BranchFlag,
  input  logic [PC_W-1:0]  Target,
  output logic [PC_W-1:0]  ProgCtr,
  output logic [LUT_W-1:0] LutIdx,
  output logic             Stall,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    LOAD_WAIT = 2'd2,
    HALT      = 2'd3
  } state_t;

  localparam logic [PC_W-1:0]  START_PC_V = PC_W'(START_PC);
  localparam logic [PC_W-1:0]  PC_ONE     = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             running_q, running_d;
  logic             done_q, done_d;

  logic is_halt, is_branch, is_load, branch_taken;

  // Instruction decode
  always_comb begin
    is_halt      = (Instruction == 9'h0FF);
    is_branch    = (Instruction[8] == 1'b0) && (Instruction[6] == 1'b1) && !is_halt;
    is_load      = (Instruction[8:6] == 3'b110);
    branch_taken = is_branch && (Instruction[7] || BranchFlag);
  end

  // Next-state, PC, arm and cycle-counter logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    if (Start) begin
      // Start aborts anything in flight, including a pending load write-back.
      state_d = IDLE;
      pc_d    = START_PC_V;
      armed_d = 1'b1;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (armed_q) begin
            state_d = RUN;
            armed_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (is_halt) begin
            state_d = HALT;
          end else if (is_load) begin
            state_d = LOAD_WAIT;
          end else if (branch_taken) begin
            pc_d = Target;
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end
        LOAD_WAIT: begin
          pc_d    = pc_q + PC_ONE;
          state_d = RUN;
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
      if (((state_q == RUN) || (state_q == LOAD_WAIT)) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end
    running_d = (state_d == RUN) || (state_d == LOAD_WAIT);
    done_d    = (state_d == HALT);
  end

  // State and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      pc_q      <= START_PC_V;
      armed_q   <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  // Stall must react to the instruction in the same cycle, so it stays combinational.
  always_comb begin
    Stall  = (state_q == RUN) && is_load;
    LutIdx = Instruction[LUT_W-1:0];
  end

  assign ProgCtr  = pc_q;
  assign Running  = running_q;
  assign Done     = done_q;
  assign CycleCnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: step, halt, loads, branches, wrap and abort.
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, Start, BranchFlag;
  logic [8:0]  instr;
  logic [9:0]  tgt;
  logic [9:0]  pc;
  logic [4:0]  lut_idx;
  logic        stall, running, done;
  logic [15:0] cnt;

  logic [3:0]  pc2;
  logic [4:0]  lut_idx2;
  logic        stall2, running2, done2;
  logic [15:0] cnt2;

  logic [8:0]  rom [0:1023];
  int          n_total = 0;
  int          n_pass  = 0;

  always #5 Clk = ~Clk;
  assign instr = rom[pc];

  pc_sequencer #(.PC_W(10)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(instr),
    .BranchFlag(BranchFlag), .Target(tgt), .ProgCtr(pc), .LutIdx(lut_idx),
    .Stall(stall), .Running(running), .Done(done), .CycleCnt(cnt)
  );

  pc_sequencer #(.PC_W(4)) dut_w4 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(9'h000),
    .BranchFlag(1'b0), .Target(4'h0), .ProgCtr(pc2), .LutIdx(lut_idx2),
    .Stall(stall2), .Running(running2), .Done(done2), .CycleCnt(cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Leaves both DUTs in the first RUN cycle at PC 0.
  task automatic restart();
    Start = 1'b1;
    step(1);
    Start = 1'b0;
    step(1);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
  endtask

  initial begin
    clear_rom();
    Reset = 1'b1; Start = 1'b0; BranchFlag = 1'b0; tgt = 10'd20;
    step(2);
    check("rst_pc", pc, 0);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_cnt", cnt, 0);
    check("rst_stall", stall, 0);

    // 1: straight-line stepping
    Reset = 1'b0; Start = 1'b1;
    step(2);
    check("t1_idle_running", running, 0);
    check("t1_idle_pc", pc, 0);
    Start = 1'b0;
    step(1);
    check("t1_running", running, 1);
    check("t1_pc0", pc, 0);
    step(1);
    check("t1_pc1", pc, 1);
    step(1);
    check("t1_pc2", pc, 2);
    check("t1_cnt", cnt, 2);

    // 2: halt at PC 1
    rom[1] = 9'h0FF;
    restart();
    check("t2_pc0", pc, 0);
    step(1);
    check("t2_pc1", pc, 1);
    step(1);
    check("t2_done", done, 1);
    check("t2_running", running, 0);
    check("t2_pc_held", pc, 1);
    check("t2_cnt", cnt, 2);
    step(3);
    check("t2_pc_frozen", pc, 1);
    check("t2_cnt_frozen", cnt, 2);
    check("t2_done_held", done, 1);
    rom[1] = 9'h000;

    // 3: single load, then back-to-back loads
    rom[3] = 9'h180;
    restart();
    step(3);
    check("t3_pc3a", pc, 3);
    check("t3_stall1", stall, 1);
    step(1);
    check("t3_pc3b", pc, 3);
    check("t3_stall0", stall, 0);
    check("t3_running_lw", running, 1);
    step(1);
    check("t3_pc4", pc, 4);
    rom[4] = 9'h180;
    restart();
    step(3);
    check("t3b_pc3a", pc, 3);
    check("t3b_stall_a", stall, 1);
    step(1);
    check("t3b_pc3b", pc, 3);
    check("t3b_nostall_a", stall, 0);
    step(1);
    check("t3b_pc4a", pc, 4);
    check("t3b_stall_b", stall, 1);
    step(1);
    check("t3b_pc4b", pc, 4);
    check("t3b_nostall_b", stall, 0);
    step(1);
    check("t3b_pc5", pc, 5);
    clear_rom();

    // 4: branches at PC 5 with Target 20
    rom[5] = 9'h045;
    BranchFlag = 1'b1;
    restart();
    step(5);
    check("t4_pc5", pc, 5);
    check("t4_lutidx", lut_idx, 5);
    step(1);
    check("t4_cond_taken", pc, 20);
    BranchFlag = 1'b0;
    restart();
    step(6);
    check("t4_cond_not_taken", pc, 6);
    rom[5] = 9'h0C5;
    restart();
    step(6);
    check("t4_uncond", pc, 20);
    clear_rom();

    // 6: abort during LOAD_WAIT, then Reset+Start together
    rom[7] = 9'h180;
    restart();
    step(7);
    check("t6_pc7", pc, 7);
    check("t6_stall", stall, 1);
    step(1);
    Start = 1'b1;
    step(1);
    check("t6_abort_pc", pc, 0);
    check("t6_abort_stall", stall, 0);
    check("t6_abort_cnt", cnt, 0);
    check("t6_abort_running", running, 0);
    Start = 1'b0;
    step(1);
    check("t6_rearmed_run", running, 1);
    Reset = 1'b1; Start = 1'b1;
    step(1);
    Reset = 1'b0; Start = 1'b0;
    step(3);
    check("t6_unarmed_running", running, 0);
    check("t6_unarmed_pc", pc, 0);
    check("t6_unarmed_cnt", cnt, 0);
    clear_rom();

    // 5: 4-bit PC wraps from 15 to 0 without halting
    restart();
    check("t5_pc0", pc2, 0);
    step(15);
    check("t5_pc15", pc2, 15);
    step(1);
    check("t5_wrap", pc2, 0);
    check("t5_no_done", done2, 0);
    check("t5_running", running2, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
